// File: rtl/result_pack_tx_pkg.sv
// Shared widths, exponent field position and packer state encodings for the
// result packer and its buffer control.
package result_pack_tx_pkg;

  localparam int DATA_W = 128;
  localparam int PACK_W = 256;
  localparam int EXP_HI = 14;
  localparam int EXP_LO = 7;
  localparam int EXP_W  = EXP_HI - EXP_LO + 1;

  localparam logic [0:0] HALF_EMPTY = 1'b0;
  localparam logic [0:0] HALF_FULL  = 1'b1;

  function automatic logic [EXP_W-1:0] exp_max(input logic [EXP_W-1:0] a,
                                               input logic [EXP_W-1:0] b);
    logic [EXP_W-1:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/result_pack_tx_if.sv
// Line input and packed-word output handshake of the result packer.
interface result_pack_tx_if
  import result_pack_tx_pkg::*;
();

  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic [PACK_W-1:0] out_data;
  logic              out_vld;
  logic              out_ready;
  logic              out_last;

  modport master (
    output in_data, in_vld, out_ready,
    input  out_data, out_vld, out_last
  );

  modport slave (
    input  in_data, in_vld, out_ready,
    output out_data, out_vld, out_last
  );

endinterface

// File: rtl/result_pack_tx_pack_fifo.sv
// First-word-fall-through FIFO holding {last, packed word}; a push into a full
// FIFO is accepted only alongside a pop, otherwise it is dropped.
module pack_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty_o   = (count_q == {(AW + 1){1'b0}});
  assign full_o    = (count_q == FULL_CNT);
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  // Empty FIFO presents zero so the output is defined straight out of reset.
  assign rd_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/result_pack_tx.sv
// Packs pairs of 128-bit result lines into 256-bit words tagged with node end.
// Define RESULT_PACK_MAXEXP_EN to enable per-node max-exponent tracking.
module result_pack_tx
  import result_pack_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  result_pack_tx_if.slave      bus,
  input  logic [LINE_W-1:0]    num_of_line_per_node_minusone,
  output logic                 overflow,
  output logic [EXP_W-1:0]     max_exponent,
  output logic                 max_exponent_vld
);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] half_q, half_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0] n_q, n_d;
  logic              overflow_q, overflow_d;
  logic [LINE_W-1:0] n_eff_s;
  logic              is_last_s;
  logic              push_s;
  logic [PACK_W:0]   push_word_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [PACK_W:0]   rd_word_s;

  // The line count per node is captured on the node's first line only.
  always_comb begin
    n_eff_s     = (line_cnt_q == {LINE_W{1'b0}}) ? num_of_line_per_node_minusone : n_q;
    is_last_s   = (line_cnt_q == n_eff_s);
    state_d     = state_q;
    half_d      = half_q;
    line_cnt_d  = line_cnt_q;
    n_d         = n_q;
    push_s      = 1'b0;
    push_word_s = {(PACK_W + 1){1'b0}};
    if (bus.in_vld) begin
      n_d        = n_eff_s;
      line_cnt_d = is_last_s ? {LINE_W{1'b0}} : line_cnt_q + {{(LINE_W - 1){1'b0}}, 1'b1};
      case (state_q)
        HALF_EMPTY: begin
          if (is_last_s) begin
            push_s      = 1'b1;
            push_word_s = {1'b1, bus.in_data, {DATA_W{1'b0}}};
          end else begin
            half_d  = bus.in_data;
            state_d = HALF_FULL;
          end
        end
        HALF_FULL: begin
          push_s      = 1'b1;
          push_word_s = {is_last_s, half_q, bus.in_data};
          state_d     = HALF_EMPTY;
        end
        default: begin
          state_d = HALF_EMPTY;
        end
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  assign pop_s      = ~empty_s & bus.out_ready;
  assign overflow_d = overflow_q | (push_s & full_s & ~pop_s);

  // Packer, line counter and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HALF_EMPTY;
      half_q     <= {DATA_W{1'b0}};
      line_cnt_q <= {LINE_W{1'b0}};
      n_q        <= {LINE_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      line_cnt_q <= line_cnt_d;
      n_q        <= n_d;
      overflow_q <= overflow_d;
    end
  end

  pack_fifo #(
    .WIDTH (PACK_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_word_s),
    .pop_i       (bus.out_ready),
    .rd_data_o   (rd_word_s),
    .empty_o     (empty_s),
    .full_o      (full_s)
  );

  assign bus.out_vld  = ~empty_s;
  assign bus.out_data = rd_word_s[PACK_W-1:0];
  assign bus.out_last = rd_word_s[PACK_W];
  assign overflow     = overflow_q;

`ifdef RESULT_PACK_MAXEXP_EN
  logic [EXP_W-1:0] run_max_q, run_max_d;
  logic [EXP_W-1:0] mx_q, mx_d;
  logic             mx_vld_q, mx_vld_d;
  logic [EXP_W-1:0] cand_s;

  // Running max restarts at zero once the node's final line is folded in.
  always_comb begin
    cand_s    = exp_max(run_max_q, bus.in_data[EXP_HI:EXP_LO]);
    run_max_d = run_max_q;
    mx_d      = mx_q;
    mx_vld_d  = 1'b0;
    if (bus.in_vld) begin
      if (is_last_s) begin
        run_max_d = {EXP_W{1'b0}};
        mx_d      = cand_s;
        mx_vld_d  = 1'b1;
      end else begin
        run_max_d = cand_s;
      end
    end else begin
      mx_vld_d = 1'b0;
    end
  end

  // Max-exponent result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_q <= {EXP_W{1'b0}};
      mx_q      <= {EXP_W{1'b0}};
      mx_vld_q  <= 1'b0;
    end else begin
      run_max_q <= run_max_d;
      mx_q      <= mx_d;
      mx_vld_q  <= mx_vld_d;
    end
  end

  assign max_exponent     = mx_q;
  assign max_exponent_vld = mx_vld_q;
`else
  assign max_exponent     = {EXP_W{1'b0}};
  assign max_exponent_vld = 1'b0;
`endif

endmodule

// File: tb/tb_result_pack_tx.sv
// Directed and random stimulus against a queue-based model of the result packer.
module tb_result_pack_tx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] n_cur;
  logic        overflow;
  logic [7:0]  max_exponent;
  logic        max_exponent_vld;

  always #5 clk = ~clk;

  result_pack_tx_if bus ();

  result_pack_tx #(
    .FIFO_DEPTH (DEPTH),
    .LINE_W     (11)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .bus                           (bus),
    .num_of_line_per_node_minusone (n_cur),
    .overflow                      (overflow),
    .max_exponent                  (max_exponent),
    .max_exponent_vld              (max_exponent_vld)
  );

  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic [256:0] mq[$];
  logic [127:0] pend[$];
  logic [7:0]   node_exp[$];
  int           pos = 0;
  int           ncap = 0;
  logic         ovf = 1'b0;
  logic [7:0]   mx_val = 8'd0;
  logic         mx_pulse = 1'b0;

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] with_exp(input logic [7:0] e);
    logic [127:0] t;
    t = rnd128();
    t[14:7] = e;
    return t;
  endfunction

  // Reference behaviour at one rising edge, from the pairing and FIFO rules.
  task automatic model_edge(input logic v, input logic [127:0] d, input logic r);
    logic         pop;
    logic         have_word;
    logic         last;
    logic [256:0] w;
    logic [7:0]   m;
    int           sz;
    mx_pulse = 1'b0;
    if (rst) begin
      mq.delete();
      pend.delete();
      node_exp.delete();
      pos = 0;
      ovf = 1'b0;
      mx_val = 8'd0;
    end else begin
      have_word = 1'b0;
      w = '0;
      sz = mq.size();
      pop = r && (sz != 0);
      if (v) begin
        if (pos == 0) ncap = int'(n_cur);
        pend.push_back(d);
        node_exp.push_back(d[14:7]);
        last = (pos == ncap);
        if (pend.size() == 2 || last) begin
          w = {last, pend[0], (pend.size() == 2) ? pend[1] : 128'd0};
          have_word = 1'b1;
          pend.delete();
        end
        if (last) begin
          m = 8'd0;
          foreach (node_exp[k]) if (node_exp[k] > m) m = node_exp[k];
          mx_val = m;
          mx_pulse = 1'b1;
          node_exp.delete();
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (pop) void'(mq.pop_front());
      if (have_word) begin
        if (sz == DEPTH && !pop) ovf = 1'b1;
        else mq.push_back(w);
      end
    end
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic r);
    logic [7:0] exp_mx;
    logic       exp_pulse;
    bus.in_vld    = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    model_edge(v, d, r);
    @(negedge clk);
`ifdef RESULT_PACK_MAXEXP_EN
    exp_mx    = mx_val;
    exp_pulse = mx_pulse;
`else
    exp_mx    = 8'd0;
    exp_pulse = 1'b0;
`endif
    chk("out_vld", {256'd0, bus.out_vld}, {256'd0, mq.size() != 0});
    if (mq.size() != 0) chk("out_word", {bus.out_last, bus.out_data}, mq[0]);
    chk("overflow", {256'd0, overflow}, {256'd0, ovf});
    chk("mx_vld", {256'd0, max_exponent_vld}, {256'd0, exp_pulse});
    chk("mx_val", {249'd0, max_exponent}, {249'd0, exp_mx});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, rnd128(), 1'b1);
    rst = 1'b0;
    chk("rst_out_data", {1'b0, bus.out_data}, 257'd0);
    chk("rst_out_last", {256'd0, bus.out_last}, 257'd0);
  endtask

  initial begin
    logic [7:0] exps [4];
    logic [7:0] want_mx;
    logic       want_pulse;
    rst = 1'b1;
    n_cur = 11'd0;
    bus.in_vld = 1'b0;
    bus.in_data = 128'd0;
    bus.out_ready = 1'b0;
    do_reset();

    // Four-line node, consumer always ready.
    n_cur = 11'd3;
    for (int i = 0; i < 4; i++) step(1'b1, rnd128(), 1'b1);
    repeat (2) step(1'b0, 128'd0, 1'b1);

    // Three-line node ends zero-padded; the next node starts in the upper half.
    n_cur = 11'd2;
    for (int i = 0; i < 3; i++) step(1'b1, rnd128(), 1'b1);
    n_cur = 11'd1;
    for (int i = 0; i < 2; i++) step(1'b1, rnd128(), 1'b1);
    step(1'b0, 128'd0, 1'b1);

    // Single-line nodes.
    n_cur = 11'd0;
    for (int i = 0; i < 3; i++) step(1'b1, rnd128(), 1'b1);
    repeat (2) step(1'b0, 128'd0, 1'b1);

    // Stalled consumer: 2*DEPTH+2 lines, the 17th word is dropped.
    n_cur = 11'd33;
    for (int i = 0; i < 2 * DEPTH + 2; i++) step(1'b1, rnd128(), 1'b0);
    chk("ovf_set", {256'd0, overflow}, 257'd1);
    repeat (DEPTH + 2) step(1'b0, 128'd0, 1'b1);
    do_reset();

    // Full FIFO with a simultaneous push and pop.
    n_cur = 11'd31;
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, rnd128(), 1'b0);
    step(1'b1, rnd128(), 1'b0);
    step(1'b1, rnd128(), 1'b1);
    chk("full_pushpop_no_ovf", {256'd0, overflow}, 257'd0);
    step(1'b1, rnd128(), 1'b0);
    step(1'b1, rnd128(), 1'b0);
    chk("full_still_full", {256'd0, overflow}, 257'd1);
    repeat (DEPTH + 2) step(1'b0, 128'd0, 1'b1);
    do_reset();

    // Reset after the first line of a node.
    n_cur = 11'd1;
    step(1'b1, rnd128(), 1'b1);
    do_reset();
    chk("rst_mid_vld", {256'd0, bus.out_vld}, 257'd0);
    for (int i = 0; i < 2; i++) step(1'b1, rnd128(), 1'b1);
    repeat (2) step(1'b0, 128'd0, 1'b1);

    // Max exponent over a four-line node.
    exps[0] = 8'h10; exps[1] = 8'h7F; exps[2] = 8'h22; exps[3] = 8'h05;
`ifdef RESULT_PACK_MAXEXP_EN
    want_mx = 8'h7F;
    want_pulse = 1'b1;
`else
    want_mx = 8'h00;
    want_pulse = 1'b0;
`endif
    n_cur = 11'd3;
    for (int i = 0; i < 4; i++) step(1'b1, with_exp(exps[i]), 1'b1);
    chk("mx_dir_pulse", {256'd0, max_exponent_vld}, {256'd0, want_pulse});
    chk("mx_dir_val", {249'd0, max_exponent}, {249'd0, want_mx});
    step(1'b0, 128'd0, 1'b1);
    chk("mx_dir_pulse_end", {256'd0, max_exponent_vld}, 257'd0);
    chk("mx_dir_hold", {249'd0, max_exponent}, {249'd0, want_mx});

    // Random traffic with a line count that changes every cycle.
    for (int i = 0; i < 400; i++) begin
      n_cur = 11'($urandom_range(0, 4));
      step(1'($urandom_range(0, 1)), with_exp(8'($urandom)), 1'($urandom_range(0, 3) != 0));
    end
    repeat (DEPTH + 2) step(1'b0, 128'd0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
